// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and operand bundle for serial_magnitude_comparator.
// The master drives start and the operands. The slave returns busy, done and the two-bit result.
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] first;
   logic [WIDTH-1:0] second;
   logic             busy;
   logic             done;
   logic [1:0]       out;

   modport master (output start, output first, output second,
                   input  busy,  input  done,  input  out);
   modport slave  (input  start, input  first, input  second,
                   output busy,  output done,  output out);
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first digit-serial magnitude comparator: out 00 equal, 01 first greater, 10 second greater.
// Defining SERIAL_CMP_EARLY_EXIT_EN ends the scan on the first differing digit.
module serial_magnitude_comparator #(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 2,
   parameter int SIGNED = 0
) (
   input logic                          clock,
   input logic                          reset,
   serial_magnitude_comparator_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] a_r, b_r;
   logic [CW-1:0]    cnt_r;
   logic [1:0]       dec_r, dec_s, out_r;
   logic             busy_r, done_r;
   logic [DIGIT-1:0] sa_s, sb_s;
   logic             flip_s, finish_s, accept_s;

   // Top-digit compare. In signed mode both sign bits are flipped on the first digit only,
   // which maps two's-complement order onto unsigned order.
   always_comb begin
      flip_s = (SIGNED != 0) && (cnt_r == CW'(N));
      sa_s   = a_r[WIDTH-1 -: DIGIT] ^ (flip_s ? MSB_MASK : {DIGIT{1'b0}});
      sb_s   = b_r[WIDTH-1 -: DIGIT] ^ (flip_s ? MSB_MASK : {DIGIT{1'b0}});
      if ((dec_r == 2'b00) && (sa_s != sb_s)) begin
         dec_s = (sa_s > sb_s) ? 2'b01 : 2'b10;
      end else begin
         dec_s = dec_r;
      end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      finish_s = (cnt_r == CW'(1)) || ((dec_r == 2'b00) && (sa_s != sb_s));
`else
      finish_s = (cnt_r == CW'(1));
`endif
   end

   // Next-state logic. A start is accepted from IDLE or DONE only.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         RUN: begin
            state_s = finish_s ? DONE : RUN;
         end
         DONE: begin
            if (bus.start) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers. out changes only on entry to DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         dec_r   <= 2'b00;
         out_r   <= 2'b00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == RUN);
         done_r  <= (state_s == DONE);
         if (accept_s) begin
            a_r   <= bus.first;
            b_r   <= bus.second;
            cnt_r <= CW'(N);
            dec_r <= 2'b00;
         end else if (state_r == RUN) begin
            a_r   <= a_r << DIGIT;
            b_r   <= b_r << DIGIT;
            cnt_r <= cnt_r - CW'(1);
            dec_r <= dec_s;
            if (finish_s) begin
               out_r <= dec_s;
            end
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.out  = out_r;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: unsigned and signed comparators run side by side on identical stimulus,
// checked cycle by cycle against an arithmetic reference model.
module tb_serial_magnitude_comparator;
   localparam int W = 8;
   localparam int D = 2;
   localparam int N = W / D;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   logic [1:0] prev_u, prev_s;

   always #5 clock = ~clock;

   serial_magnitude_comparator_if #(.WIDTH(W)) if_u ();
   serial_magnitude_comparator_if #(.WIDTH(W)) if_s ();

   serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .SIGNED(0)) u_dut_u (
      .clock(clock), .reset(reset), .bus(if_u));
   serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .SIGNED(1)) u_dut_s (
      .clock(clock), .reset(reset), .bus(if_s));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result: plain integer compare of the operand values.
   function automatic logic [1:0] ref_res(input logic [7:0] a, input logic [7:0] b, input bit sgn);
      int ia, ib;
      ia = int'(a);
      ib = int'(b);
      if (sgn && a >= 8'd128) ia -= 256;
      if (sgn && b >= 8'd128) ib -= 256;
      if (ia > ib) return 2'b01;
      else if (ia < ib) return 2'b10;
      else return 2'b00;
   endfunction

   // Reference latency: index of the first differing digit (early exit) or the full scan.
   function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
      int jd;
      jd = N;
      for (int j = N; j >= 1; j--) begin
         if ((a >> (W - j * D)) != (b >> (W - j * D))) jd = j;
      end
      return EE ? jd + 1 : N + 1;
   endfunction

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
      if_u.start = s; if_u.first = a; if_u.second = b;
      if_s.start = s; if_s.first = a; if_s.second = b;
   endtask

   // One compare on both DUTs. pre: start already driven in the current cycle.
   // inject: stray start with new operands in cycle 2. chain: keep start high into DONE with na/nb.
   task automatic run(input logic [7:0] a, input logic [7:0] b, input bit pre, input bit inject,
                      input bit chain, input logic [7:0] na, input logic [7:0] nb);
      int lat;
      logic [1:0] eu, es;
      lat = ref_lat(a, b);
      eu  = ref_res(a, b, 1'b0);
      es  = ref_res(a, b, 1'b1);
      if (!pre) begin
         @(negedge clock);
         drive(a, b, 1'b1);
      end
      for (int cyc = 1; cyc <= lat; cyc++) begin
         @(negedge clock);
         chk($sformatf("busy_u %h/%h c%0d", a, b, cyc), if_u.busy, (cyc < lat));
         chk($sformatf("done_u %h/%h c%0d", a, b, cyc), if_u.done, (cyc == lat));
         chk($sformatf("busy_s %h/%h c%0d", a, b, cyc), if_s.busy, (cyc < lat));
         chk($sformatf("done_s %h/%h c%0d", a, b, cyc), if_s.done, (cyc == lat));
         if (cyc < lat) begin
            chk($sformatf("hold_u %h/%h c%0d", a, b, cyc), if_u.out, prev_u);
            chk($sformatf("hold_s %h/%h c%0d", a, b, cyc), if_s.out, prev_s);
         end else begin
            chk($sformatf("out_u %h/%h", a, b), if_u.out, eu);
            chk($sformatf("out_s %h/%h", a, b), if_s.out, es);
         end
         if (cyc == 1) begin
            if (chain) drive(na, nb, 1'b1);
            else drive(a, b, 1'b0);
         end
         if (inject && cyc == 2) drive(~a, b ^ 8'h3C, 1'b1);
         if (inject && cyc == 3) drive(a, b, 1'b0);
      end
      prev_u = eu;
      prev_s = es;
   endtask

   initial begin
      logic [7:0] ra, rb;
      reset = 1'b1;
      drive(8'h00, 8'h00, 1'b0);
      prev_u = 2'b00;
      prev_s = 2'b00;
      repeat (2) @(negedge clock);
      chk("rst_busy_u", if_u.busy, 1'b0);
      chk("rst_done_u", if_u.done, 1'b0);
      chk("rst_out_u",  if_u.out,  2'b00);
      chk("rst_busy_s", if_s.busy, 1'b0);
      chk("rst_done_s", if_s.done, 1'b0);
      chk("rst_out_s",  if_s.out,  2'b00);
      reset = 1'b0;

      run(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run(8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run(8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run(8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      repeat (3) begin
         @(negedge clock);
         chk("idle_hold_u", if_u.out, prev_u);
         chk("idle_hold_s", if_s.out, prev_s);
         chk("idle_busy_u", if_u.busy, 1'b0);
      end

      run(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

      run(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h40, 8'h00);
      run(8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFE);
      run(8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 24; i++) begin
         ra = 8'($urandom);
         case (i % 4)
            0: rb = ra;
            1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
            default: rb = 8'($urandom);
         endcase
         run(ra, rb, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end

      run(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clock);
      drive(8'h3C, 8'h3C, 1'b1);
      @(negedge clock);
      drive(8'h3C, 8'h3C, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("midrst_busy_u", if_u.busy, 1'b0);
      chk("midrst_done_u", if_u.done, 1'b0);
      chk("midrst_out_u",  if_u.out,  2'b00);
      chk("midrst_busy_s", if_s.busy, 1'b0);
      chk("midrst_out_s",  if_s.out,  2'b00);
      @(negedge clock);
      reset = 1'b0;
      prev_u = 2'b00;
      prev_s = 2'b00;
      run(8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Multi-cycle magnitude comparator for two WIDTH-bit operands. It scans the operands MSB-first, DIGIT bits per cycle, under a start/busy/done handshake. The result uses the same two-bit encoding as the team's combinational comparators: 00 means equal, 01 means first greater, 10 means second greater. It sits in datapaths where wide operands make a single-cycle compare too slow, and where a signed mode is needed.

## Interface
Parameters:
- WIDTH, 8 — operand width in bits; ≥ 2.
- DIGIT, 2 — bits compared per cycle; must divide WIDTH. N = WIDTH/DIGIT.
- SIGNED, 0 — 0 selects unsigned compare; 1 selects two's-complement compare.

Ports:
- clock  in  1  — rising-edge clock.
- reset  in  1  — asynchronous, active-high reset.
- start  in  1  — request a compare; accepted only when not busy.
- first  in  WIDTH  — operand A; sampled on the accepting edge only.
- second  in  WIDTH  — operand B; sampled on the accepting edge only.
- busy  out  1  — high while a compare is in progress (RUN).
- done  out  1  — one-cycle pulse; out is valid from this cycle.
- out  out  2  — result: 00 equal, 01 first > second, 10 second > first. 11 is never driven.

## Operation
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any time, including mid-RUN):
  - State goes to IDLE.
  - busy=0, done=0, out=00.
  - Operand shift registers, digit counter and decision flags are cleared.
- IDLE or DONE with start=1:
  - Latch first/second into shift registers.
  - Load counter with N, clear the decision, go to RUN.
  - start while in RUN is ignored; operands are not re-sampled.
- RUN, each cycle:
  - Compare the top DIGIT bits of both shift registers as unsigned values.
  - When SIGNED=1, invert the operand MSB for the first digit only. This turns two's-complement ordering into unsigned ordering.
  - While undecided and the slices differ, record the decision: 01 if A's slice is greater, else 10. Once recorded, the decision is never overwritten.
  - Shift both registers left by DIGIT and decrement the counter.
- RUN → DONE when the counter reaches 0 after the last digit, or early per Configuration. On that edge, out takes the decision (00 if none was recorded).
- DONE lasts one cycle with done=1, then goes to IDLE unless start=1, which goes straight to RUN.
- out holds its value through IDLE and the next RUN. It changes only on entry to DONE or on reset.

## Timing
- Cycle 0: start=1 sampled on the edge ending cycle 0.
- Cycles 1..N: RUN, busy=1.
- Cycle N+1: DONE, done=1, out valid. Latency is N+1 cycles from start to done.
- Early exit (macro enabled): if the first differing digit is digit j (1-based), DONE occurs in cycle j+1. Equal operands always take N+1.
- Back-to-back: start asserted in the DONE cycle gives the next RUN in the following cycle. Throughput is one compare per N+1 cycles.
- busy and done are never high together.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN:
  - Defined: RUN → DONE on the same edge the first decision is recorded. The remaining digits are skipped.
  - Undefined: RUN always lasts exactly N cycles, regardless of the data. This gives fixed latency for schedulers that need it.
  - out is identical in both builds.

## Test plan
All scenarios use WIDTH=8, DIGIT=2.
- Equal operands: start with 0xA5 vs 0xA5 → busy in cycles 1–4; done in cycle 5 with out=00 (both builds).
- Unsigned greater: 0x80 vs 0x7F with SIGNED=0 → out=01. Swapped operands → out=10.
- Signed: 0x80 vs 0x7F with SIGNED=1 → out=10. 0xFF vs 0xFE → out=01. 0x00 vs 0xFF → out=01.
- Early exit: 0x40 vs 0x00 → out=01 with done in cycle 2 when the macro is defined, cycle 5 when undefined. Difference only in the LSB digit (0x01 vs 0x00) → done in cycle 5 in both builds.
- Handshake and hold:
  - start pulsed in cycle 2 with new operands → ignored; the result is for the original pair.
  - start held through DONE → next compare begins immediately.
  - out holds between compares.
- Reset mid-RUN: assert reset in cycle 2 → same-cycle busy=0, done=0, out=00. After release, a fresh start completes normally.
